adder_seq: RTL and testbench

Multi-byte addition sequencer built around one shared `adderPlus` 8-bit adder instance. It accepts two NBYTES-wide operands over a valid/ready handshake and walks them through the adder one byte at a time, least-significant byte first. Because `adderPlus` has no carry-in, the sequencer propagates carry by issuing an extra increment pass through the same adder whenever the previous byte carried. The result is returned on a valid/ready output channel. It sits between the operand source and the result consumer, giving wide adds without replicating the adder.

---
 rtl/adder_seq.sv | 110 +++++++++++
 tb/tb_adder_seq.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/adder_seq.sv
// adder_seq: adds two NBYTES-wide operands one byte at a time through a single shared 8-bit adder,
// recovering the missing carry-in with an extra increment pass through the same adder.
module adderPlus (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] s_o,
  output logic       co_o
);
  assign {co_o, s_o} = {1'b0, a_i} + {1'b0, b_i};
endmodule

module adder_seq #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   op_a,
  input  logic [8*NBYTES-1:0]   op_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   out_sum,
  output logic                  out_carry,
  output logic                  busy
);
  localparam int IW = $clog2(NBYTES);
  typedef enum logic [1:0] {IDLE, ADD, INC, DONE} state_t;
  state_t              state_q, state_d;
  logic [8*NBYTES-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [IW-1:0]       idx_q, idx_d, idx_nxt;
  logic                carry_q, carry_d, cadd_q, cadd_d;
  logic [7:0]          add_a, add_b, add_s;
  logic                add_co, last;
  logic [IW+2:0]       bo;
  assign bo        = {idx_q, 3'b000};
  assign last      = idx_q == IW'(NBYTES - 1);
  assign idx_nxt   = last ? '0 : idx_q + IW'(1);
  assign in_ready  = state_q == IDLE && !rst;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign out_sum   = acc_q;
  assign out_carry = carry_q;
  // Adder inputs are zero outside ADD/INC so the shared adder sits quiet.
  assign add_a = state_q == ADD ? a_q[bo +: 8] : state_q == INC ? acc_q[bo +: 8] : 8'h00;
  assign add_b = state_q == ADD ? b_q[bo +: 8] : state_q == INC ? 8'h01 : 8'h00;
  adderPlus u_add (
    .a_i (add_a),
    .b_i (add_b),
    .s_o (add_s),
    .co_o(add_co)
  );
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cadd_d  = cadd_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d     = op_a;
        b_d     = op_b;
        acc_d   = '0;
        carry_d = 1'b0;
        cadd_d  = 1'b0;
        idx_d   = '0;
        state_d = ADD;
      end
      ADD: begin
        acc_d[bo +: 8] = add_s;
        cadd_d         = add_co;
        // A pending carry from the previous byte is folded in by an INC pass.
        carry_d        = carry_q ? carry_q : add_co;
        idx_d          = carry_q ? idx_q : idx_nxt;
        state_d        = carry_q ? INC : last ? DONE : ADD;
      end
      INC: begin
        acc_d[bo +: 8] = add_s;
        carry_d        = cadd_q | add_co;
        idx_d          = idx_nxt;
        state_d        = last ? DONE : ADD;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cadd_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cadd_q  <= cadd_d;
    end
  end
  // A byte that already carried out is at most 0xFE, so the increment cannot carry again.
  assert property (@(posedge clk) disable iff (rst) (state_q == INC) |-> !(cadd_q && add_co));
endmodule

// File: tb/tb_adder_seq.sv
// tb_adder_seq: directed and small randomized checks of the byte-serial adder sequencer.
module tb_adder_seq;
  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] op_a = '0, op_b = '0;
  logic        in_ready, out_valid, out_carry, busy;
  logic [31:0] out_sum;
  int          n_checks = 0, n_fail = 0;

  adder_seq #(.NBYTES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_carry(out_carry), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int kcount(input logic [31:0] a, input logic [31:0] b);
    int k = 0;
    for (int i = 1; i < 4; i++) begin
      logic [63:0] m, lo;
      m  = (64'd1 << (8 * i)) - 64'd1;
      lo = ({32'd0, a} & m) + ({32'd0, b} & m);
      if (((lo >> (8 * i)) & 64'd1) != 0) k++;
    end
    return k;
  endfunction

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] es,
                       input logic ec, input int el, input string nm);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s in_ready: got %b want 1", nm, in_ready); end
    in_valid = 1'b1; op_a = a; op_b = b; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    n_checks++;
    if (n !== el) begin n_fail++; $display("FAIL %s latency: got %0d want %0d", nm, n, el); end
    n_checks++;
    if (out_sum !== es) begin n_fail++; $display("FAIL %s sum: got %h want %h", nm, out_sum, es); end
    n_checks++;
    if (out_carry !== ec) begin n_fail++; $display("FAIL %s carry: got %b want %b", nm, out_carry, ec); end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL %s busy: got %b want 1", nm, busy); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s release: out_valid=%b in_ready=%b want 0/1", nm, out_valid, in_ready);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b1; op_a = 32'h1; op_b = 32'h2;
    repeat (2) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst in_ready: got %b want 0", in_ready); end
    n_checks++;
    if ({out_valid, busy, out_carry} !== 3'b000 || out_sum !== 32'h0) begin
      n_fail++; $display("FAIL rst outputs: valid/busy/carry=%b sum=%h want 000/0", {out_valid, busy, out_carry}, out_sum);
    end
    in_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL post_rst idle: in_ready=%b busy=%b want 1/0", in_ready, busy);
    end
  endtask

  task automatic test_directed;
    do_op(32'h00000001, 32'h00000002, 32'h00000003, 1'b0, 4, "small");
    do_op(32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 7, "ripple");
    do_op(32'h80808080, 32'h80808080, 32'h01010100, 1'b1, 7, "excl");
    do_op(32'h00FF00FF, 32'h00010001, 32'h01000100, 1'b0, 6, "alt");
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 7, "max");
    do_op(32'h7F000000, 32'h81000000, 32'h00000000, 1'b1, 4, "top_carry");
    do_op(32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 5, "one_inc");
  endtask

  task automatic test_backpressure;
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; op_a = 32'h1; op_b = 32'h2; out_ready = 1'b0;
    @(negedge clk);
    op_a = 32'hAAAAAAAA; op_b = 32'h55555555;
    while (out_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 32'h3 || out_carry !== 1'b0) begin
        n_fail++;
        $display("FAIL bp hold %0d: valid=%b ready=%b sum=%h carry=%b want 1/0/00000003/0", i, out_valid, in_ready, out_sum, out_carry);
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL bp release: valid=%b ready=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_back_to_back;
    int t[$];
    @(negedge clk);
    op_a = 32'h1; op_b = 32'h2; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 30 && t.size() < 3; c++) begin
      if (in_ready && in_valid) t.push_back(c);
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (t.size() != 3) begin
      n_fail++; $display("FAIL b2b accepts: got %0d want 3", t.size());
    end else begin
      n_checks++;
      if (t[1] - t[0] != 6 || t[2] - t[1] != 6) begin
        n_fail++; $display("FAIL b2b spacing: got %0d,%0d want 6,6", t[1] - t[0], t[2] - t[1]);
      end
    end
  endtask

  task automatic test_reset_midop;
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    in_valid = 1'b1; op_a = 32'hFFFFFFFF; op_b = 32'h1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL midop busy: got %b want 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_sum !== 32'h0 || out_carry !== 1'b0) begin
      n_fail++; $display("FAIL midop rst: busy=%b valid=%b sum=%h carry=%b want 0/0/0/0", busy, out_valid, out_sum, out_carry);
    end
    do_op(32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 4, "after_rst");
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      logic [32:0] s;
      a = $urandom;
      b = (i % 4 == 0) ? ~a + 32'd1 : $urandom;
      s = {1'b0, a} + {1'b0, b};
      do_op(a, b, s[31:0], s[32], 4 + kcount(a, b), "rand");
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_backpressure;
    test_back_to_back;
    test_reset_midop;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
